// File: rtl/sv39_ptw_walker_pkg.sv
// Shared types for the SV39 page-table walker slice.
// Ports: none (package): walker FSM states, SV39 PTE layout, TLB update bundle.
// Helper vpn_slice() selects the 9-bit VPN field for a given walk level.
package sv39_ptw_walker_pkg;

    localparam int unsigned PPN_W = 44;
    localparam int unsigned VPN_W = 9;
    localparam int unsigned VA_W  = 39;
    localparam int unsigned PTE_W = 64;
    localparam int unsigned PA_W  = PPN_W + VPN_W + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } ptw_state_e;

    // SV39 PTE, MSB first: bits 63:54 reserved, 53:10 PPN, 9:8 RSW, 7:0 flags.
    typedef struct packed {
        logic [9:0]       reserved;
        logic [PPN_W-1:0] ppn;
        logic [1:0]       rsw;
        logic             d;
        logic             a;
        logic             g;
        logic             u;
        logic             x;
        logic             w;
        logic             r;
        logic             v;
    } pte_sv39_t;

    typedef struct packed {
        logic [26:0] vpn;
        logic        is_2M;
        logic        is_1G;
        pte_sv39_t   content;
    } tlb_update_t;

    function automatic logic [VPN_W-1:0] vpn_slice(input logic [VA_W-1:0] va,
                                                   input logic [1:0]      lvl);
        logic [VPN_W-1:0] s;
        case (lvl)
            2'd2:    s = va[38:30];
            2'd1:    s = va[29:21];
            default: s = va[20:12];
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sv39_ptw_walker_pte_check.sv
// Combinational SV39 PTE classifier: leaf detection and page-fault decision.
// Ports: PTE flag bits, low 18 PPN bits, walk level, store flag -> leaf, page_fault.
// No state; bus errors are handled by the caller with higher priority.
module sv39_ptw_walker_pte_check (
    input  logic        v,
    input  logic        r,
    input  logic        w,
    input  logic        x,
    input  logic        a,
    input  logic        d,
    input  logic [17:0] ppn_lo,
    input  logic [1:0]  level,
    input  logic        is_store,
    output logic        leaf,
    output logic        page_fault
);

    logic invalid;
    logic misaligned;
    logic leaf_fault;
    logic last_level;

    // W without R is a reserved encoding and is treated like an invalid PTE.
    assign invalid    = ~v | (~r & w);
    assign leaf       = r | x;

    // A superpage leaf must have its lower PPN fields zero.
    assign misaligned = ((level == 2'd2) && (ppn_lo != 18'd0)) ||
                        ((level == 2'd1) && (ppn_lo[8:0] != 9'd0));

    // A/D are never set by hardware, so missing bits fault to software.
    assign leaf_fault = misaligned | ~a | (is_store & ~d);
    assign last_level = (level == 2'd0);

    assign page_fault = invalid | (leaf ? leaf_fault : last_level);

endmodule

// File: rtl/sv39_ptw_walker.sv
// SV39 hardware page-table walker: TLB miss in, one TLB update or one fault out.
// Ports: clk_i/rst_ni, flush_i, satp_ppn_i, req_* (miss), mem_req_*/mem_rsp_* (PTE read),
//        upd_* (TLB refill pulse), fault_* (failure pulse), busy_o.
// One PTE read outstanding; a flushed walk drains its response silently.
module sv39_ptw_walker
    import sv39_ptw_walker_pkg::*;
#(
    parameter int unsigned ASID_WIDTH = 1,
    parameter int unsigned PLEN       = 56
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [43:0]           satp_ppn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [38:0]           req_vaddr_i,
    input  logic [ASID_WIDTH-1:0] req_asid_i,
    input  logic                  req_is_store_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [PLEN-1:0]       mem_req_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [63:0]           mem_rsp_data_i,
    input  logic                  mem_rsp_err_i,
    output logic                  upd_valid_o,
    output logic [26:0]           upd_vpn_o,
    output logic [ASID_WIDTH-1:0] upd_asid_o,
    output logic                  upd_is_2M_o,
    output logic                  upd_is_1G_o,
    output logic [63:0]           upd_content_o,
    output logic                  fault_valid_o,
    output logic                  fault_access_o,
    output logic [38:0]           fault_vaddr_o,
    output logic                  busy_o
);

    ptw_state_e state_q, state_d;

    logic [VA_W-1:0]       vaddr_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic                  is_store_q;
    logic [1:0]            level_q;
    logic [PPN_W-1:0]      base_q;
    logic                  fault_q;
    logic                  access_q;
    tlb_update_t           upd_q;

    pte_sv39_t             rsp_pte;
    logic                  pte_leaf;
    logic                  pte_fault;
    logic                  accept;
    logic                  rsp_take;
    logic [PA_W-1:0]       addr_full;

    assign rsp_pte = pte_sv39_t'(mem_rsp_data_i);

    sv39_ptw_walker_pte_check u_pte_check (
        .v          (rsp_pte.v),
        .r          (rsp_pte.r),
        .w          (rsp_pte.w),
        .x          (rsp_pte.x),
        .a          (rsp_pte.a),
        .d          (rsp_pte.d),
        .ppn_lo     (rsp_pte.ppn[17:0]),
        .level      (level_q),
        .is_store   (is_store_q),
        .leaf       (pte_leaf),
        .page_fault (pte_fault)
    );

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        req_ready_o     = 1'b0;
        mem_req_valid_o = 1'b0;
        upd_valid_o     = 1'b0;
        fault_valid_o   = 1'b0;
        accept          = 1'b0;
        rsp_take        = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = ~flush_i;
                if (req_valid_i && !flush_i) begin
                    accept  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_req_valid_o = 1'b1;
                if (flush_i) begin
                    // A granted read still owes a response and must be drained.
                    state_d = mem_req_ready_i ? S_DRAIN : S_IDLE;
                end else if (mem_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = mem_rsp_valid_i ? S_IDLE : S_DRAIN;
                end else if (mem_rsp_valid_i) begin
                    rsp_take = 1'b1;
                    if (mem_rsp_err_i || pte_fault || pte_leaf) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DRAIN: begin
                if (mem_rsp_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                upd_valid_o   = ~flush_i & ~fault_q;
                fault_valid_o = ~flush_i &  fault_q;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Walk context and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vaddr_q    <= '0;
            asid_q     <= '0;
            is_store_q <= 1'b0;
            level_q    <= 2'd0;
            base_q     <= '0;
            fault_q    <= 1'b0;
            access_q   <= 1'b0;
            upd_q      <= '0;
        end else begin
            if (accept) begin
                vaddr_q    <= req_vaddr_i;
                asid_q     <= req_asid_i;
                is_store_q <= req_is_store_i;
                level_q    <= 2'd2;
                base_q     <= satp_ppn_i;
            end
            if (rsp_take) begin
                if (mem_rsp_err_i) begin
                    fault_q  <= 1'b1;
                    access_q <= 1'b1;
                end else if (pte_fault) begin
                    fault_q  <= 1'b1;
                    access_q <= 1'b0;
                end else if (pte_leaf) begin
                    fault_q       <= 1'b0;
                    access_q      <= 1'b0;
                    upd_q.vpn     <= vaddr_q[38:12];
                    upd_q.is_1G   <= (level_q == 2'd2);
                    upd_q.is_2M   <= (level_q == 2'd1);
                    upd_q.content <= rsp_pte;
                end else begin
                    base_q  <= rsp_pte.ppn;
                    level_q <= level_q - 2'd1;
                end
            end
        end
    end

    assign addr_full      = {base_q, vpn_slice(vaddr_q, level_q), 3'b000};
    assign mem_req_addr_o = PLEN'(addr_full);

    assign upd_vpn_o      = upd_q.vpn;
    assign upd_asid_o     = asid_q;
    assign upd_is_2M_o    = upd_q.is_2M;
    assign upd_is_1G_o    = upd_q.is_1G;
    assign upd_content_o  = upd_q.content;
    assign fault_access_o = access_q;
    assign fault_vaddr_o  = vaddr_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sv39_ptw_walker.sv
// Directed bench for sv39_ptw_walker: walks, faults, flush and backpressure.
// Ports: none; drives the walker and models memory cycle-by-cycle.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_sv39_ptw_walker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [43:0] satp_ppn;
    logic        req_valid;
    logic        req_ready;
    logic [38:0] req_vaddr;
    logic [0:0]  req_asid;
    logic        req_is_store;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [55:0] mem_req_addr;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        upd_valid;
    logic [26:0] upd_vpn;
    logic [0:0]  upd_asid;
    logic        upd_is_2M;
    logic        upd_is_1G;
    logic [63:0] upd_content;
    logic        fault_valid;
    logic        fault_access;
    logic [38:0] fault_vaddr;
    logic        busy;

    int checks  = 0;
    int errors  = 0;
    int upd_cnt = 0;
    int flt_cnt = 0;

    localparam logic [38:0] VA  = 39'h00_4040_3123;  // vpn2=1 vpn1=2 vpn0=3
    localparam logic [38:0] VA3 = 39'h7F_FFFF_F000;  // vpn2=0x1FF

    always #5 clk = ~clk;

    sv39_ptw_walker #(.ASID_WIDTH(1), .PLEN(56)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .satp_ppn_i      (satp_ppn),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_vaddr_i     (req_vaddr),
        .req_asid_i      (req_asid),
        .req_is_store_i  (req_is_store),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_rsp_valid_i (rsp_valid),
        .mem_rsp_data_i  (rsp_data),
        .mem_rsp_err_i   (rsp_err),
        .upd_valid_o     (upd_valid),
        .upd_vpn_o       (upd_vpn),
        .upd_asid_o      (upd_asid),
        .upd_is_2M_o     (upd_is_2M),
        .upd_is_1G_o     (upd_is_1G),
        .upd_content_o   (upd_content),
        .fault_valid_o   (fault_valid),
        .fault_access_o  (fault_access),
        .fault_vaddr_o   (fault_vaddr),
        .busy_o          (busy)
    );

    // Count every pulse so stray updates/faults anywhere are caught at the end.
    always begin
        @(negedge clk);
        #2;
        if (upd_valid)   upd_cnt++;
        if (fault_valid) flt_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Handshake in cycle T; returns settled inside cycle T+1.
    task automatic do_req(input logic [38:0] va, input logic st);
        @(negedge clk);
        req_valid    = 1'b1;
        req_vaddr    = va;
        req_asid     = 1'b1;
        req_is_store = st;
        #1;
        chk("req_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
    endtask

    // Check the ISSUE cycle, answer in the following cycle, return one cycle after.
    task automatic serve(input string tag, input logic [55:0] addr,
                         input logic [63:0] pte, input logic err);
        chk({tag, "_vld"},  {63'd0, mem_req_valid}, 64'd1);
        chk({tag, "_addr"}, {8'd0, mem_req_addr}, {8'd0, addr});
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data  = pte;
        rsp_err   = err;
        #1;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = 64'd0;
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        satp_ppn      = 44'h80000;
        req_valid     = 1'b0;
        req_vaddr     = '0;
        req_asid      = '0;
        req_is_store  = 1'b0;
        mem_req_ready = 1'b1;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        rsp_err       = 1'b0;

        // Reset state
        #2;
        chk("rst_req_ready",  {63'd0, req_ready}, 64'd1);
        chk("rst_busy",       {63'd0, busy}, 64'd0);
        chk("rst_mem_vld",    {63'd0, mem_req_valid}, 64'd0);
        chk("rst_upd_vld",    {63'd0, upd_valid}, 64'd0);
        chk("rst_fault_vld",  {63'd0, fault_valid}, 64'd0);
        chk("rst_content",    upd_content, 64'd0);
        chk("rst_fvaddr",     {25'd0, fault_vaddr}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // 4K walk: three reads, update in T+7
        do_req(VA, 1'b0);
        chk("4k_busy", {63'd0, busy}, 64'd1);
        serve("4k_l2", 56'h8000_0008, 64'h2000_0401, 1'b0);
        serve("4k_l1", 56'h8000_1010, 64'h2000_0801, 1'b0);
        serve("4k_l0", 56'h8000_2018, 64'h048D_1443, 1'b0);
        chk("4k_upd_vld",   {63'd0, upd_valid}, 64'd1);
        chk("4k_fault_vld", {63'd0, fault_valid}, 64'd0);
        chk("4k_vpn",       {37'd0, upd_vpn}, 64'h40403);
        chk("4k_asid",      {63'd0, upd_asid}, 64'd1);
        chk("4k_is_2M",     {63'd0, upd_is_2M}, 64'd0);
        chk("4k_is_1G",     {63'd0, upd_is_1G}, 64'd0);
        chk("4k_content",   upd_content, 64'h048D_1443);
        cyc();
        chk("4k_idle_busy", {63'd0, busy}, 64'd0);
        chk("4k_idle_upd",  {63'd0, upd_valid}, 64'd0);

        // 2M leaf at level 1
        do_req(VA, 1'b0);
        serve("2m_l2", 56'h8000_0008, 64'h2000_0401, 1'b0);
        serve("2m_l1", 56'h8000_1010, 64'h0008_0043, 1'b0);
        chk("2m_upd_vld", {63'd0, upd_valid}, 64'd1);
        chk("2m_is_2M",   {63'd0, upd_is_2M}, 64'd1);
        chk("2m_is_1G",   {63'd0, upd_is_1G}, 64'd0);

        // 1G leaf, aligned
        do_req(VA, 1'b0);
        serve("1g_l2", 56'h8000_0008, 64'h1000_004B, 1'b0);
        chk("1g_upd_vld", {63'd0, upd_valid}, 64'd1);
        chk("1g_is_1G",   {63'd0, upd_is_1G}, 64'd1);
        chk("1g_is_2M",   {63'd0, upd_is_2M}, 64'd0);
        chk("1g_content", upd_content, 64'h1000_004B);

        // 1G leaf with ppn[0]=1: misaligned superpage
        do_req(VA, 1'b0);
        serve("mis_l2", 56'h8000_0008, 64'h1000_044B, 1'b0);
        chk("mis_fault_vld", {63'd0, fault_valid}, 64'd1);
        chk("mis_access",    {63'd0, fault_access}, 64'd0);
        chk("mis_upd_vld",   {63'd0, upd_valid}, 64'd0);

        // Store to leaf with D=0
        do_req(VA3, 1'b1);
        serve("st_l2", 56'h8000_0FF8, 64'h1000_004B, 1'b0);
        chk("st_fault_vld", {63'd0, fault_valid}, 64'd1);
        chk("st_access",    {63'd0, fault_access}, 64'd0);
        chk("st_fvaddr",    {25'd0, fault_vaddr}, {25'd0, VA3});

        // Store to leaf with D=1 succeeds
        do_req(VA3, 1'b1);
        serve("std_l2", 56'h8000_0FF8, 64'h1000_00CB, 1'b0);
        chk("std_upd_vld", {63'd0, upd_valid}, 64'd1);
        chk("std_vpn",     {37'd0, upd_vpn}, 64'h7FF_FFFF);

        // Bus error at level 1
        do_req(VA, 1'b0);
        serve("err_l2", 56'h8000_0008, 64'h2000_0401, 1'b0);
        serve("err_l1", 56'h8000_1010, 64'h0, 1'b1);
        chk("err_fault_vld", {63'd0, fault_valid}, 64'd1);
        chk("err_access",    {63'd0, fault_access}, 64'd1);
        chk("err_upd_vld",   {63'd0, upd_valid}, 64'd0);
        chk("err_fvaddr",    {25'd0, fault_vaddr}, {25'd0, VA});

        // Flush in WAIT, response three cycles later
        do_req(VA, 1'b0);
        chk("fw_mem_vld", {63'd0, mem_req_valid}, 64'd1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fw_wait_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fw_drain_busy",  {63'd0, busy}, 64'd1);
        chk("fw_drain_ready", {63'd0, req_ready}, 64'd0);
        chk("fw_drain_mem",   {63'd0, mem_req_valid}, 64'd0);
        cyc();
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data  = 64'h048D_1443;
        #1;
        chk("fw_rsp_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_data  = 64'd0;
        #1;
        chk("fw_after_busy",  {63'd0, busy}, 64'd0);
        chk("fw_after_ready", {63'd0, req_ready}, 64'd1);
        chk("fw_after_upd",   {63'd0, upd_valid}, 64'd0);
        chk("fw_after_fault", {63'd0, fault_valid}, 64'd0);

        // Backpressure: request held for 5 cycles, then flushed without grant
        mem_req_ready = 1'b0;
        do_req(VA, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld",  {63'd0, mem_req_valid}, 64'd1);
            chk("bp_addr", {8'd0, mem_req_addr}, 64'h8000_0008);
            if (i < 4) cyc();
        end
        flush = 1'b1;
        #1;
        chk("bp_flush_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        flush         = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("bp_idle_busy",  {63'd0, busy}, 64'd0);
        chk("bp_idle_mem",   {63'd0, mem_req_valid}, 64'd0);
        chk("bp_idle_ready", {63'd0, req_ready}, 64'd1);

        // Flush blocks acceptance in IDLE; stray response in IDLE is ignored
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("idle_flush_ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        flush     = 1'b0;
        rsp_valid = 1'b1;
        #1;
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        chk("stray_rsp_busy", {63'd0, busy}, 64'd0);

        // Walker still functional afterwards
        do_req(VA, 1'b0);
        serve("post_l2", 56'h8000_0008, 64'h1000_004B, 1'b0);
        chk("post_upd_vld", {63'd0, upd_valid}, 64'd1);
        cyc();
        cyc();

        chk("upd_pulse_count",   upd_cnt, 64'd5);
        chk("fault_pulse_count", flt_cnt, 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
